result_unloader: RTL



---
 rtl/result_unloader.sv | 106 ++++++++++
 1 files changed

// File: rtl/result_unloader.sv
// Result vector unloader: captures a full result vector in one cycle and
// streams it out one element per valid/ready handshake, lowest index first.
module result_unloader #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 4,
  parameter int IDX_W  = (N_ELEM > 2) ? $clog2(N_ELEM) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     res_valid,
  input  logic [N_ELEM*ELEM_W-1:0] res_data,
  output logic                     res_ready,
  input  logic                     flush,
  output logic [ELEM_W-1:0]        dout,
  output logic [IDX_W-1:0]         dout_idx,
  output logic                     dout_valid,
  output logic                     dout_last,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t                   state_reg, state_next;
  logic [N_ELEM*ELEM_W-1:0] shadow_reg, shadow_next;
  logic [IDX_W-1:0]         idx_reg, idx_next, idx_inc;
  logic [ELEM_W-1:0]        dout_reg, dout_next;
  logic [ELEM_W-1:0]        shadow_elem [N_ELEM];

  // Element view of the shadow register for indexed selection.
  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
      assign shadow_elem[gi] = shadow_reg[gi*ELEM_W +: ELEM_W];
    end
  endgenerate

  assign idx_inc = idx_reg + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      idx_reg    <= '0;
      dout_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      idx_reg    <= idx_next;
      dout_reg   <= dout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    idx_next    = idx_reg;
    dout_next   = dout_reg;
    case (state_reg)
      IDLE: begin
        // flush outranks a simultaneous capture request
        if (res_valid && !flush) begin
          shadow_next = res_data;
          dout_next   = res_data[ELEM_W-1:0];
          idx_next    = '0;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (flush) begin
          state_next = IDLE;
        end else if (dout_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next  = idx_inc;
            dout_next = shadow_elem[idx_inc];
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decode directly from the state register.
  assign res_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign dout_valid = (state_reg == SEND);
  assign dout_last  = dout_valid && (idx_reg == LAST_IDX);
  assign dout       = dout_reg;
  assign dout_idx   = idx_reg;

endmodule
